// File: rtl/sysid_checker.sv
// Avalon-MM master that reads the system-ID slave (word 0 = ID, word 1 = build timestamp),
// compares both words against the expected image values, and publishes the result as status.
module sysid_checker #(
  parameter logic [31:0] EXPECTED_ID    = 32'hACD51302,
  parameter logic [31:0] EXPECTED_TS    = 32'h5616570D,
  parameter int unsigned READ_LATENCY   = 0,
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter bit          AUTO_START     = 1'b1
) (
  input  logic        i_clock,
  input  logic        i_reset,
  input  logic        i_start,
  output logic        o_avm_address,
  output logic        o_avm_read,
  input  logic [31:0] i_avm_readdata,
  input  logic        i_avm_waitrequest,
  output logic        o_busy,
  output logic        o_done,
  output logic [31:0] o_id_value,
  output logic [31:0] o_ts_value,
  output logic        o_id_match,
  output logic        o_ts_match,
  output logic        o_timeout_err
);

  localparam logic [15:0] STALL_LIMIT = 16'(TIMEOUT_CYCLES - 1);
  localparam logic [1:0]  LAT_LAST    = 2'((READ_LATENCY == 0) ? 0 : READ_LATENCY - 1);

  typedef enum logic [2:0] {IDLE, RD_ID, LAT_ID, RD_TS, LAT_TS, FIN} state_t;

  state_t      r_state;
  state_t      w_state_next;
  logic        r_auto_pend;
  logic        r_read;
  logic        r_address;
  logic        r_busy;
  logic        r_done;
  logic [15:0] r_stall_cnt;
  logic [1:0]  r_lat_cnt;
  logic [31:0] r_id_value;
  logic [31:0] r_ts_value;
  logic        r_id_match;
  logic        r_ts_match;
  logic        r_timeout_err;

  logic w_clear;
  logic w_cap_id;
  logic w_cap_ts;
  logic w_timeout;

  always_comb begin
    w_state_next = r_state;
    w_clear      = 1'b0;
    w_cap_id     = 1'b0;
    w_cap_ts     = 1'b0;
    w_timeout    = 1'b0;
    case (r_state)
      IDLE: begin
        if (i_start || r_auto_pend) begin
          w_state_next = RD_ID;
          w_clear      = 1'b1;
        end
      end
      RD_ID: begin
        // An accept in the cycle the stall count would hit the limit wins over the timeout.
        if (!i_avm_waitrequest) begin
          if (READ_LATENCY == 0) begin
            w_cap_id     = 1'b1;
            w_state_next = RD_TS;
          end else begin
            w_state_next = LAT_ID;
          end
        end else if (r_stall_cnt == STALL_LIMIT) begin
          w_timeout    = 1'b1;
          w_state_next = FIN;
        end
      end
      LAT_ID: begin
        if (r_lat_cnt == LAT_LAST) begin
          w_cap_id     = 1'b1;
          w_state_next = RD_TS;
        end
      end
      RD_TS: begin
        if (!i_avm_waitrequest) begin
          if (READ_LATENCY == 0) begin
            w_cap_ts     = 1'b1;
            w_state_next = FIN;
          end else begin
            w_state_next = LAT_TS;
          end
        end else if (r_stall_cnt == STALL_LIMIT) begin
          w_timeout    = 1'b1;
          w_state_next = FIN;
        end
      end
      LAT_TS: begin
        if (r_lat_cnt == LAT_LAST) begin
          w_cap_ts     = 1'b1;
          w_state_next = FIN;
        end
      end
      FIN:     w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_state       <= IDLE;
      r_auto_pend   <= AUTO_START;
      r_read        <= 1'b0;
      r_address     <= 1'b0;
      r_busy        <= 1'b0;
      r_done        <= 1'b0;
      r_stall_cnt   <= '0;
      r_lat_cnt     <= '0;
      r_id_value    <= '0;
      r_ts_value    <= '0;
      r_id_match    <= 1'b0;
      r_ts_match    <= 1'b0;
      r_timeout_err <= 1'b0;
    end else begin
      r_state     <= w_state_next;
      r_auto_pend <= 1'b0;
      // Bus and status strobes are registered from the next state so they align with it.
      r_read      <= (w_state_next == RD_ID) || (w_state_next == RD_TS);
      r_address   <= (w_state_next == RD_TS);
      r_busy      <= (w_state_next != IDLE);
      r_done      <= (w_state_next == FIN);

      if (w_state_next != r_state) begin
        r_stall_cnt <= '0;
      end else if (r_read && i_avm_waitrequest) begin
        r_stall_cnt <= r_stall_cnt + 16'd1;
      end

      if (w_state_next != r_state) begin
        r_lat_cnt <= '0;
      end else if ((r_state == LAT_ID) || (r_state == LAT_TS)) begin
        r_lat_cnt <= r_lat_cnt + 2'd1;
      end

      if (w_clear) begin
        r_id_value    <= '0;
        r_ts_value    <= '0;
        r_id_match    <= 1'b0;
        r_ts_match    <= 1'b0;
        r_timeout_err <= 1'b0;
      end
      if (w_cap_id) begin
        r_id_value <= i_avm_readdata;
      end
      // Match flags are settled as FIN is entered so they are valid alongside done.
      if (w_cap_ts) begin
        r_ts_value <= i_avm_readdata;
        r_id_match <= (r_id_value == EXPECTED_ID);
        r_ts_match <= (i_avm_readdata == EXPECTED_TS);
      end
      if (w_timeout) begin
        r_timeout_err <= 1'b1;
      end
    end
  end

  assign o_avm_read    = r_read;
  assign o_avm_address = r_address;
  assign o_busy        = r_busy;
  assign o_done        = r_done;
  assign o_id_value    = r_id_value;
  assign o_ts_value    = r_ts_value;
  assign o_id_match    = r_id_match;
  assign o_ts_match    = r_ts_match;
  assign o_timeout_err = r_timeout_err;

endmodule

// File: tb/tb_sysid_checker.sv
// Bench for sysid_checker: two instances (read latency 0 and 2, timeout 8) each behind a
// behavioural system-ID slave with programmable stall and stuck-waitrequest behaviour.
module tb_sysid_checker;

  localparam logic [31:0] EXP_ID = 32'hACD51302;
  localparam logic [31:0] EXP_TS = 32'h5616570D;
  localparam int          TMO    = 8;

  typedef struct {
    int          inst;
    logic [31:0] id;
    logic [31:0] ts;
    int          w;
    bit          s0;
    bit          s1;
    bit          exp_idm;
    bit          exp_tsm;
    bit          exp_to;
  } vec_t;

  logic        clk;
  logic        rst;
  logic [1:0]  start;
  logic [1:0]  address;
  logic [1:0]  read;
  logic [1:0]  waitreq;
  logic [1:0]  busy;
  logic [1:0]  done;
  logic [1:0]  idm;
  logic [1:0]  tsm;
  logic [1:0]  toe;
  logic [31:0] rdata [2];
  logic [31:0] idv [2];
  logic [31:0] tsv [2];

  logic [31:0] mem_id [2];
  logic [31:0] mem_ts [2];
  int          wait_n [2];
  logic [1:0]  stuck0;
  logic [1:0]  stuck1;

  int n_vec = 0;
  int n_bad = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  for (genvar gi = 0; gi < 2; gi++) begin : g_inst
    localparam int LAT = (gi == 0) ? 0 : 2;
    int   wcnt = 0;
    logic stall_now;
    logic accept;
    logic pv [3];
    logic pa [3];
    logic dvalid;
    logic daddr;

    sysid_checker #(
      .EXPECTED_ID   (EXP_ID),
      .EXPECTED_TS   (EXP_TS),
      .READ_LATENCY  (LAT),
      .TIMEOUT_CYCLES(TMO),
      .AUTO_START    (1'b1)
    ) dut (
      .i_clock          (clk),
      .i_reset          (rst),
      .i_start          (start[gi]),
      .o_avm_address    (address[gi]),
      .o_avm_read       (read[gi]),
      .i_avm_readdata   (rdata[gi]),
      .i_avm_waitrequest(waitreq[gi]),
      .o_busy           (busy[gi]),
      .o_done           (done[gi]),
      .o_id_value       (idv[gi]),
      .o_ts_value       (tsv[gi]),
      .o_id_match       (idm[gi]),
      .o_ts_match       (tsm[gi]),
      .o_timeout_err    (toe[gi])
    );

    always_comb begin
      stall_now = read[gi] && ((address[gi] ? stuck1[gi] : stuck0[gi]) || (wcnt < wait_n[gi]));
      accept    = read[gi] && !stall_now;
    end
    assign waitreq[gi] = stall_now;

    always @(posedge clk) begin
      wcnt  <= stall_now ? wcnt + 1 : 0;
      pv[0] <= accept;
      pa[0] <= address[gi];
      pv[1] <= pv[0];
      pa[1] <= pa[0];
      pv[2] <= pv[1];
      pa[2] <= pa[1];
    end

    // Data is only valid in the cycle the slave's latency says; otherwise it is junk.
    if (LAT == 0) begin : g_l0
      assign dvalid = accept;
      assign daddr  = address[gi];
    end else begin : g_ln
      assign dvalid = pv[LAT-1];
      assign daddr  = pa[LAT-1];
    end
    assign rdata[gi] = dvalid ? (daddr ? mem_ts[gi] : mem_id[gi]) : 32'hDEADBEEF;
  end

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endfunction

  function automatic vec_t mk(int inst, logic [31:0] id, logic [31:0] ts, int w, bit s0, bit s1,
                              bit e_idm, bit e_tsm, bit e_to);
    vec_t v;
    v.inst = inst; v.id = id; v.ts = ts; v.w = w; v.s0 = s0; v.s1 = s1;
    v.exp_idm = e_idm; v.exp_tsm = e_tsm; v.exp_to = e_to;
    return v;
  endfunction

  // Reference: a read either times out (stuck or >= TMO stall cycles) or completes after w+1
  // request cycles plus the slave latency; a timeout on word 0 skips word 1 entirely.
  function automatic vec_t model_flags(vec_t v);
    vec_t r = v;
    bit to = v.s0 || v.s1 || (v.w >= TMO);
    r.exp_to  = to;
    r.exp_idm = !to && (v.id == EXP_ID);
    r.exp_tsm = !to && (v.ts == EXP_TS);
    return r;
  endfunction

  task automatic configure(input vec_t v);
    mem_id[v.inst] = v.id;
    mem_ts[v.inst] = v.ts;
    wait_n[v.inst] = v.w;
    stuck0[v.inst] = v.s0;
    stuck1[v.inst] = v.s1;
  endtask

  // Called at the negedge of the first cycle after the launching edge.
  task automatic observe(input vec_t v, input string tag);
    int k = v.inst;
    int lat = (k == 0) ? 0 : 2;
    bit to0 = v.s0 || (v.w >= TMO);
    bit to1 = v.s1 || (v.w >= TMO);
    int exp_reads = to0 ? TMO : (v.w + 1) + (to1 ? TMO : v.w + 1);
    int exp_done = to0 ? TMO + 1 : (v.w + 1 + lat) + (to1 ? TMO : v.w + 1 + lat) + 1;
    logic [31:0] exp_id = to0 ? 32'h0 : v.id;
    logic [31:0] exp_ts = (to0 || to1) ? 32'h0 : v.ts;
    int cyc = 1, reads = 0, dones = 0, done_cyc = 0;
    logic busy_at = 1'b0, busy_after = 1'b1;
    logic [31:0] id_s = 32'hX, ts_s = 32'hX;
    logic idm_s = 1'bX, tsm_s = 1'bX, to_s = 1'bX;
    while (cyc < 150) begin
      if (read[k]) reads++;
      if (done[k]) begin
        dones++;
        if (done_cyc == 0) begin
          done_cyc = cyc;
          busy_at  = busy[k];
        end
      end
      if (done_cyc != 0 && cyc == done_cyc + 1) begin
        busy_after = busy[k];
        id_s = idv[k]; ts_s = tsv[k];
        idm_s = idm[k]; tsm_s = tsm[k]; to_s = toe[k];
      end
      if (done_cyc != 0 && cyc == done_cyc + 3) break;
      @(negedge clk);
      cyc++;
    end
    chk({tag, " done_cycle"}, done_cyc, exp_done);
    chk({tag, " done_pulses"}, dones, 1);
    chk({tag, " read_cycles"}, reads, exp_reads);
    chk({tag, " busy_at_done"}, {31'b0, busy_at}, 32'd1);
    chk({tag, " busy_after"}, {31'b0, busy_after}, 32'd0);
    chk({tag, " id_value"}, id_s, exp_id);
    chk({tag, " ts_value"}, ts_s, exp_ts);
    chk({tag, " id_match"}, {31'b0, idm_s}, {31'b0, v.exp_idm});
    chk({tag, " ts_match"}, {31'b0, tsm_s}, {31'b0, v.exp_tsm});
    chk({tag, " timeout_err"}, {31'b0, to_s}, {31'b0, v.exp_to});
    $display("%s inst%0d w=%0d stuck=%0d%0d: done@%0d reads=%0d id=%08h ts=%08h m=%0d%0d to=%0d",
             tag, k, v.w, v.s0, v.s1, done_cyc, reads, id_s, ts_s, idm_s, tsm_s, to_s);
  endtask

  task automatic run(input vec_t v, input string tag);
    configure(v);
    @(negedge clk);
    start[v.inst] = 1'b1;
    @(negedge clk);
    start[v.inst] = 1'b0;
    observe(v, tag);
  endtask

  // Start pattern per cycle on instance 0; compare the cycles in which done pulses.
  task automatic hand_seq(input logic [15:0] smask, input logic [15:0] exp_dmask,
                          input int clear_cyc, input string tag);
    logic [15:0] dmask = '0;
    for (int c = 0; c < 16; c++) begin
      dmask[c] = done[0];
      if (c == clear_cyc) begin
        chk({tag, " cleared_id_value"}, idv[0], 32'h0);
        chk({tag, " cleared_id_match"}, {31'b0, idm[0]}, 32'd0);
        chk({tag, " busy_new_check"}, {31'b0, busy[0]}, 32'd1);
      end
      start[0] = smask[c];
      @(negedge clk);
    end
    start[0] = 1'b0;
    chk({tag, " done_cycles"}, {16'b0, dmask}, {16'b0, exp_dmask});
    $display("%s: start=%04h done=%04h", tag, smask, dmask);
  endtask

  vec_t tbl [10];
  vec_t good0, good1;

  initial begin
    good0 = mk(0, EXP_ID, EXP_TS, 0, 0, 0, 1, 1, 0);
    good1 = mk(1, EXP_ID, EXP_TS, 0, 0, 0, 1, 1, 0);
    tbl[0] = good0;
    tbl[1] = mk(0, 32'hACD51303, EXP_TS, 0, 0, 0, 0, 1, 0);
    tbl[2] = mk(1, EXP_ID, EXP_TS, 3, 0, 0, 1, 1, 0);
    tbl[3] = mk(0, EXP_ID, EXP_TS, 0, 0, 1, 0, 0, 1);
    tbl[4] = mk(1, EXP_ID, EXP_TS, 0, 0, 1, 0, 0, 1);
    tbl[5] = mk(0, EXP_ID, EXP_TS, TMO - 1, 0, 0, 1, 1, 0);
    tbl[6] = mk(0, EXP_ID, EXP_TS, TMO, 0, 0, 0, 0, 1);
    tbl[7] = mk(1, EXP_ID, EXP_TS, 1, 1, 0, 0, 0, 1);
    tbl[8] = mk(0, EXP_ID, 32'h5616570C, 2, 0, 0, 1, 0, 0);
    tbl[9] = mk(1, 32'h12345678, 32'h9ABCDEF0, 1, 0, 0, 0, 0, 0);

    start = '0;
    rst   = 1'b1;
    configure(good0);
    configure(good1);
    #1;
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("reset%0d read", k), {31'b0, read[k]}, 32'd0);
      chk($sformatf("reset%0d busy", k), {31'b0, busy[k]}, 32'd0);
      chk($sformatf("reset%0d done", k), {31'b0, done[k]}, 32'd0);
      chk($sformatf("reset%0d id_value", k), idv[k], 32'd0);
    end
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    fork
      observe(good0, "auto0");
      observe(good1, "auto1");
    join

    for (int i = 0; i < 10; i++) run(tbl[i], $sformatf("tbl%0d", i));

    configure(good0);
    hand_seq(16'b0000_0000_0000_1101, 16'b0000_0000_0000_1000, -1, "start_ignored");
    hand_seq(16'b0000_0000_0001_1101, 16'b0000_0000_1000_1000, 5, "start_after_fin");

    // Reset while instance 1 waits out the timestamp latency.
    configure(good1);
    @(negedge clk);
    start[1] = 1'b1;
    @(negedge clk);
    start[1] = 1'b0;
    repeat (4) @(negedge clk);
    chk("lat_ts busy_before_reset", {31'b0, busy[1]}, 32'd1);
    chk("lat_ts id_before_reset", idv[1], EXP_ID);
    #2 rst = 1'b1;
    #1;
    chk("lat_ts reset read", {31'b0, read[1]}, 32'd0);
    chk("lat_ts reset busy", {31'b0, busy[1]}, 32'd0);
    chk("lat_ts reset id_value", idv[1], 32'd0);
    chk("lat_ts reset id_match", {31'b0, idm[1]}, 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    fork
      observe(good0, "rerun0");
      observe(good1, "rerun1");
    join

    for (int i = 0; i < 24; i++) begin
      vec_t v;
      v.inst = $urandom_range(0, 1);
      v.id   = $urandom_range(0, 1) ? EXP_ID : $urandom();
      v.ts   = $urandom_range(0, 1) ? EXP_TS : $urandom();
      v.w    = $urandom_range(0, 9);
      v.s0   = ($urandom_range(0, 7) == 0);
      v.s1   = ($urandom_range(0, 7) == 0);
      v = model_flags(v);
      run(v, $sformatf("rnd%0d", i));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/sysid_checker.md
Name: sysid_checker

Overview:
- Avalon-MM master that sits directly upstream of the system-ID slave and consumes its readdata.
- After reset, or on request, it reads word 0 (system ID) and word 1 (build timestamp) and compares both against expected parameters.
- It publishes the captured values plus match/timeout flags to a status register block, so HPS software and LEDs can reject a stale FPGA image.

Parameters:
- EXPECTED_ID, 32'hACD51302, value required at address 0.
- EXPECTED_TS, 32'h5616570D, value required at address 1.
- READ_LATENCY, 0, fixed slave read latency in cycles after acceptance; legal range 0..3.
- TIMEOUT_CYCLES, 255, maximum cycles one read may stall on waitrequest; legal range 1..65535.
- AUTO_START, 1, 1 = start one check automatically after reset release.

Ports:
- clock  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- start  in  1  single-cycle request to run a check
- avm_address  out  1  0 = ID word, 1 = timestamp word
- avm_read  out  1  read request
- avm_readdata  in  32  slave read data
- avm_waitrequest  in  1  slave stall
- busy  out  1  check in progress
- done  out  1  one-cycle pulse when a check finishes (pass, fail or timeout)
- id_value  out  32  captured ID word
- ts_value  out  32  captured timestamp word
- id_match  out  1  id_value == EXPECTED_ID
- ts_match  out  1  ts_value == EXPECTED_TS
- timeout_err  out  1  last check aborted on stall timeout

Behaviour:
- Reset (async assert, sync release): all outputs 0, FSM in IDLE; avm_read drops combinationally-from-reset (registered, async-cleared).
- FSM states: IDLE, RD_ID, LAT_ID, RD_TS, LAT_TS, FIN.
- IDLE -> RD_ID on start, or on the first cycle after reset release when AUTO_START=1.
- Entering RD_ID clears id_value, ts_value, id_match, ts_match and timeout_err; busy=1.
- RD_ID: avm_read=1, avm_address=0, held stable until the cycle read && !waitrequest (acceptance).
  - READ_LATENCY=0: capture avm_readdata into id_value in the acceptance cycle, go to RD_TS.
  - READ_LATENCY>0: deassert read, go to LAT_ID, count READ_LATENCY cycles, capture on the last one, go to RD_TS.
- RD_TS / LAT_TS: identical handling with avm_address=1, capture into ts_value, then go to FIN.
- FIN, one cycle:
  - id_match and ts_match are registered from equality compares of the captured values.
  - done=1 for exactly this cycle; busy=0 from the next cycle; return to IDLE.
- Timeout:
  - A 16-bit stall counter resets on entering each RD state and increments every cycle with read && waitrequest.
  - When the count reaches TIMEOUT_CYCLES while still stalled: deassert read, set timeout_err=1, leave both match flags 0, go to FIN (done pulses).
  - A read accepted in the same cycle the count would reach the limit counts as accepted, not timed out.
- start while busy=1: ignored, no queuing.
- start in the FIN cycle: ignored. start in the first IDLE cycle after FIN: new check.
- Status outputs hold their values until the next check begins or reset.
- Only one outstanding read at a time; the master never issues reads back-to-back without completing the latency wait.

Test Plan:
- AUTO_START=1, slave returns 0xACD51302 / 0x5616570D, latency 0, no wait -> read at addr 0 then addr 1 on consecutive cycles; done pulses; id_match=1, ts_match=1, timeout_err=0.
- Manual start with slave returning ID 0xACD51303 -> id_match=0, ts_match=1, id_value=0xACD51303.
- READ_LATENCY=2, waitrequest high 3 cycles per read -> read held 4 cycles per word; data captured exactly 2 cycles after acceptance; both matches 1.
- TIMEOUT_CYCLES=8, waitrequest stuck high on addr 1 -> read drops after 8 stalled cycles; timeout_err=1, both matches 0, id_value still captured, done pulses once.
- Assert reset while in LAT_TS -> avm_read, busy and flags go to 0 immediately; after release with AUTO_START=1 a full fresh check runs.
- start pulsed during busy and during the FIN cycle -> ignored; start one cycle later -> new check; flags cleared on entering RD_ID.
